// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline stall controller: FSM states, the
// freeze/flush control bundle and its decode helpers.
package arm_pipe_pkg;

  localparam int STAT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic ifid_freeze;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_freeze;
    logic memwb_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(6'b000000);

  function automatic ctrl_t freeze_all();
    ctrl_t c;
    c              = CTRL_IDLE;
    c.pc_freeze    = 1'b1;
    c.ifid_freeze  = 1'b1;
    c.exmem_freeze = 1'b1;
    c.memwb_freeze = 1'b1;
    return c;
  endfunction

  // A taken branch squashes the ID instruction, so its hazard is irrelevant.
  function automatic ctrl_t run_decode(input logic branch_taken, input logic hazard);
    ctrl_t c;
    c = CTRL_IDLE;
    if (branch_taken) begin
      c.ifid_flush  = 1'b1;
      c.idex_bubble = 1'b1;
    end else if (hazard) begin
      c.pc_freeze   = 1'b1;
      c.ifid_freeze = 1'b1;
      c.idex_bubble = 1'b1;
    end else begin
      c = CTRL_IDLE;
    end
    return c;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Memory-wait watchdog: counts consecutive wait cycles and raises a sticky
// timeout flag when a stall persists past WAIT_TIMEOUT.
module stall_watchdog
  import arm_pipe_pkg::*;
#(
  parameter int WAIT_W       = 8,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clear,
  output logic at_limit,
  output logic mem_timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_TIMEOUT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  assign at_limit    = (wait_cnt_q == LIMIT);
  assign mem_timeout = timeout_q;

  // Counter holds at the limit so it can never wrap once HALT is entered.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (clear) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if (count_en) begin
      if (at_limit) begin
        timeout_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= {WAIT_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush controller for the 5-stage pipeline with a memory-wait watchdog.
// Optional saturating stall statistics are enabled with STALL_STATS_EN.
module pipeline_stall_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255,
  parameter int WAIT_W       = 8,
  parameter int STAT_W       = STAT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hazard,
  input  logic branch_taken,
  input  logic mem_req,
  input  logic mem_ready,
  output logic pc_freeze,
  output logic ifid_freeze,
  output logic ifid_flush,
  output logic idex_bubble,
  output logic exmem_freeze,
  output logic memwb_freeze,
  output logic mem_timeout,
`ifdef STALL_STATS_EN
  output logic [STAT_W-1:0] hazard_stalls,
  output logic [STAT_W-1:0] mem_stalls,
  output logic [STAT_W-1:0] flushes,
`endif
  output logic busy
);

  state_e state_q, state_d;
  ctrl_t  ctrl_s;
  logic   busy_s;
  logic   mem_stall_s, at_limit_s, count_en_s, clear_s;

  assign mem_stall_s = mem_req & ~mem_ready;
  assign count_en_s  = mem_stall_s & (state_q != ST_HALT);
  assign clear_s     = (state_q == ST_WAIT) & ~mem_stall_s;

  stall_watchdog #(
    .WAIT_W      (WAIT_W),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (count_en_s),
    .clear      (clear_s),
    .at_limit   (at_limit_s),
    .mem_timeout(mem_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // A dropped mem_req in WAIT counts as a release, same as mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  state_d = mem_stall_s ? ST_WAIT : ST_RUN;
      ST_WAIT: begin
        if (mem_stall_s) state_d = at_limit_s ? ST_HALT : ST_WAIT;
        else             state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // The release cycle of WAIT reuses the RUN priority decode on the same edge.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    busy_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        ctrl_s = mem_stall_s ? freeze_all() : run_decode(branch_taken, hazard);
        busy_s = 1'b0;
      end
      ST_WAIT: begin
        ctrl_s = mem_stall_s ? freeze_all() : run_decode(branch_taken, hazard);
        busy_s = 1'b1;
      end
      ST_HALT: begin
        ctrl_s = freeze_all();
        busy_s = 1'b1;
      end
      default: begin
        ctrl_s = freeze_all();
        busy_s = 1'b1;
      end
    endcase
  end

  assign pc_freeze    = rst_n & ctrl_s.pc_freeze;
  assign ifid_freeze  = rst_n & ctrl_s.ifid_freeze;
  assign ifid_flush   = rst_n & ctrl_s.ifid_flush;
  assign idex_bubble  = rst_n & ctrl_s.idex_bubble;
  assign exmem_freeze = rst_n & ctrl_s.exmem_freeze;
  assign memwb_freeze = rst_n & ctrl_s.memwb_freeze;
  assign busy         = rst_n & busy_s;

`ifdef STALL_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) return v + {{(STAT_W-1){1'b0}}, 1'b1};
    else                             return v;
  endfunction

  logic hz_evt_s, mem_evt_s, fl_evt_s;
  logic [STAT_W-1:0] hazard_stalls_q, mem_stalls_q, flushes_q;

  assign hz_evt_s  = (state_q != ST_HALT) & ctrl_s.pc_freeze & ~ctrl_s.exmem_freeze;
  assign mem_evt_s = (state_q != ST_HALT) & ctrl_s.exmem_freeze;
  assign fl_evt_s  = ctrl_s.ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_stalls_q <= {STAT_W{1'b0}};
      mem_stalls_q    <= {STAT_W{1'b0}};
      flushes_q       <= {STAT_W{1'b0}};
    end else begin
      hazard_stalls_q <= sat_inc(hazard_stalls_q, hz_evt_s);
      mem_stalls_q    <= sat_inc(mem_stalls_q, mem_evt_s);
      flushes_q       <= sat_inc(flushes_q, fl_evt_s);
    end
  end

  assign hazard_stalls = hazard_stalls_q;
  assign mem_stalls    = mem_stalls_q;
  assign flushes       = flushes_q;
`else
  logic [STAT_W-1:0] unused_stat_s;
  assign unused_stat_s = {STAT_W{1'b0}};
`endif

endmodule
